// File: rtl/tt_mux_sel_ctrl_pkg.sv
// Package for the mux select controller.
// Holds the default address width and the controller FSM state encoding.
package tt_mux_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    SEL_RST_LO,
    SEL_RST_HI,
    INC_HI,
    INC_LO,
    FINISH
  } state_t;

endpackage

// File: rtl/tt_mux_sel_ctrl_if.sv
// Request handshake bundle for tt_mux_sel_ctrl.
// Signals:
//   req_valid - a select request is present (master -> slave)
//   req_ready - the controller can accept a request (slave -> master)
//   req_addr  - target design address (master -> slave)
//   req_ena   - enable the selected design afterwards (master -> slave)
interface tt_mux_sel_ctrl_if
  import tt_mux_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;

  modport master (
    output req_valid,
    output req_addr,
    output req_ena,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_ena,
    output req_ready
  );

endinterface

// File: rtl/tt_mux_sel_ctrl_timer.sv
// Half-phase timer for the mux select controller.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   load   - (re)start a half-phase of PULSE_CYC cycles
//   expire - high for one cycle, the last cycle of the half-phase
module tt_mux_pulse_timer #(
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;
  logic       run;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= 4'(PULSE_CYC - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Loaded at edge e, expire is seen in cycle e+PULSE_CYC-1 so the
  // consumer changes phase exactly at edge e+PULSE_CYC.
  assign expire = run && (cnt == '0);

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// Mux select controller: drives the mux select counter (reset + increment
// pulses) so that it points at a requested design address, then enables it.
// Ports:
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset
//   req            - request handshake (slave side): valid/ready/addr/ena
//   ctrl_sel_rst_n - active-low reset to the mux select counter (registered)
//   ctrl_sel_inc   - increment strobe to the mux select counter (registered)
//   ctrl_ena       - enable for the selected design (registered)
//   done           - one-cycle pulse when a request completes
//   cur_addr       - address currently selected
//   cur_valid      - cur_addr is known
module tt_mux_sel_ctrl
  import tt_mux_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  tt_mux_sel_ctrl_if.slave  req,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ena_q;
  logic              ready;
  logic              accept;
  logic              same_addr;
  logic              rebuild;
  logic              load;
  logic              expire;

  // ready is a register that is high only while in IDLE, so accept needs
  // no separate state decode.
  assign req.req_ready = ready;
  assign accept        = req.req_valid && ready;
  assign same_addr     = cur_valid && (req.req_addr == cur_addr);
  assign rebuild       = !cur_valid || (req.req_addr < cur_addr);

  // Every timed phase starts either on accept or on the expiry of the
  // previous phase; a spare load when heading to FINISH is harmless.
  assign load = (accept && !same_addr) ||
                (expire && (state inside {SEL_RST_LO, SEL_RST_HI, INC_HI, INC_LO}));

  tt_mux_pulse_timer #(
    .PULSE_CYC(PULSE_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ready          <= 1'b0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      done           <= 1'b0;
      cur_valid      <= 1'b0;
      cur_addr       <= '0;
      cnt            <= '0;
      ena_q          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            ready <= 1'b0;
            ena_q <= req.req_ena;
            if (same_addr) begin
              state     <= FINISH;
              done      <= 1'b1;
              ctrl_ena  <= req.req_ena;
              cur_valid <= 1'b1;
            end else if (rebuild) begin
              state          <= SEL_RST_LO;
              ctrl_sel_rst_n <= 1'b0;
              ctrl_ena       <= 1'b0;
              cur_valid      <= 1'b0;
              cur_addr       <= '0;
              cnt            <= req.req_addr;
            end else begin
              state        <= INC_HI;
              ctrl_sel_inc <= 1'b1;
              ctrl_ena     <= 1'b0;
              cnt          <= req.req_addr - cur_addr;
              cur_addr     <= cur_addr + 1'b1;
            end
          end
        end

        SEL_RST_LO: begin
          if (expire) begin
            state          <= SEL_RST_HI;
            ctrl_sel_rst_n <= 1'b1;
          end
        end

        SEL_RST_HI: begin
          if (expire) begin
            if (cnt == '0) begin
              state     <= FINISH;
              done      <= 1'b1;
              ctrl_ena  <= ena_q;
              cur_valid <= 1'b1;
            end else begin
              state        <= INC_HI;
              ctrl_sel_inc <= 1'b1;
              cur_addr     <= cur_addr + 1'b1;
            end
          end
        end

        INC_HI: begin
          if (expire) begin
            state        <= INC_LO;
            ctrl_sel_inc <= 1'b0;
            cnt          <= cnt - 1'b1;
          end
        end

        INC_LO: begin
          if (expire) begin
            if (cnt == '0) begin
              state     <= FINISH;
              done      <= 1'b1;
              ctrl_ena  <= ena_q;
              cur_valid <= 1'b1;
            end else begin
              state        <= INC_HI;
              ctrl_sel_inc <= 1'b1;
              cur_addr     <= cur_addr + 1'b1;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// Self-checking bench for tt_mux_sel_ctrl (ADDR_W=10, PULSE_CYC=2).
// A driver issues directed requests and queues the hand-computed response;
// a monitor measures each completed request and compares against the queue.
module tb_tt_mux_sel_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned P  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_sel_rst_n;
  logic          ctrl_sel_inc;
  logic          ctrl_ena;
  logic          done;
  logic [AW-1:0] cur_addr;
  logic          cur_valid;

  always #5 clk = ~clk;

  tt_mux_sel_ctrl_if #(.ADDR_W(AW)) req_if ();

  tt_mux_sel_ctrl #(
    .ADDR_W   (AW),
    .PULSE_CYC(P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req_if),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_ena      (ctrl_ena),
    .done          (done),
    .cur_addr      (cur_addr),
    .cur_valid     (cur_valid)
  );

  typedef struct {
    int addr;
    int ena;
    int lat;
    int incs;
    int rstlow;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, int'(req_if.req_ready), 0);
    check({tag, "_sel_rst_n"}, int'(ctrl_sel_rst_n), 1);
    check({tag, "_sel_inc"},   int'(ctrl_sel_inc), 0);
    check({tag, "_ctrl_ena"},  int'(ctrl_ena), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_cur_valid"}, int'(cur_valid), 0);
    check({tag, "_cur_addr"},  int'(cur_addr), 0);
  endtask

  // Waits for ready (bounded), queues the expectation, and lets the accept
  // edge pass. req_valid is left high so consecutive calls are back-to-back.
  task automatic send(input int addr, input int ena, input bit push,
                      input int lat, input int incs, input int rstlow);
    bit   got;
    exp_t e;
    got = 1'b0;
    req_if.req_valid = 1'b1;
    req_if.req_addr  = AW'(addr);
    req_if.req_ena   = ena[0];
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (req_if.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_timeout", int'(got), 1);
    if (got && push) begin
      e.addr   = addr;
      e.ena    = ena;
      e.lat    = lat;
      e.incs   = incs;
      e.rstlow = rstlow;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    check("drain_timeout", int'(empty), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: measures latency, pulse counts and ctrl_ena per request.
  initial begin
    bit   inflight;
    bit   prev_inc;
    int   cyc;
    int   incs;
    int   rl;
    int   ena_hi;
    exp_t e;
    inflight = 1'b0;
    prev_inc = 1'b0;
    cyc      = 0;
    incs     = 0;
    rl       = 0;
    ena_hi   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 1'b0;
        prev_inc = 1'b0;
      end else begin
        if (inflight) begin
          cyc++;
          if (!ctrl_sel_rst_n) rl++;
          if (ctrl_sel_inc && !prev_inc) incs++;
          if (done) begin
            inflight = 1'b0;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL done_without_request actual=1 expected=0");
            end else begin
              e = q.pop_front();
              check("latency",          cyc, e.lat);
              check("inc_pulses",       incs, e.incs);
              check("sel_rst_low_cyc",  rl, e.rstlow);
              check("cur_addr",         int'(cur_addr), e.addr);
              check("cur_valid",        int'(cur_valid), 1);
              check("ctrl_ena_at_done", int'(ctrl_ena), e.ena);
              check("ctrl_ena_in_seq",  ena_hi, 0);
            end
          end else if (ctrl_ena) begin
            ena_hi++;
          end
        end else if (done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end
        prev_inc = ctrl_sel_inc;
        if (req_if.req_valid && req_if.req_ready) begin
          inflight = 1'b1;
          cyc      = 0;
          incs     = 0;
          rl       = 0;
          ena_hi   = 0;
        end
      end
    end
  end

  // Driver
  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_addr  = '0;
    req_if.req_ena   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", int'(req_if.req_ready), 1);

    // Back-to-back with req_valid held high throughout.
    send(3, 1, 1'b1, 17, 3, 2);  // rebuild from unknown
    send(5, 1, 1'b1,  9, 2, 0);  // incremental
    send(2, 1, 1'b1, 13, 2, 2);  // lower address: rebuild
    send(2, 0, 1'b1,  1, 0, 0);  // same address
    req_if.req_valid = 1'b0;
    drain();

    // A=0 rebuild, then the full-range incremental and a same-address hit.
    do_reset();
    send(0,    1, 1'b1,    5,    0, 2);
    send(1023, 0, 1'b1, 4093, 1023, 0);
    send(1023, 1, 1'b1,    1,    0, 0);
    req_if.req_valid = 1'b0;
    drain();

    // Abort an A=4 rebuild with rst in cycle 6.
    do_reset();
    send(4, 1, 1'b0, 0, 0, 0);
    req_if.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("abort");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_abort", int'(req_if.req_ready), 1);
    send(1, 1, 1'b1, 9, 1, 2);  // cur_valid cleared, so rebuild
    req_if.req_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_mux_sel_ctrl.md
TT_MUX_SEL_CTRL -- requirements
Module: tt_mux_sel_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the width of the mux design address.
REQ-002 SHALL have parameter PULSE_CYC, default 2, meaning clk cycles per half-phase of each control pulse (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a select request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request (high only in IDLE).
REQ-007 SHALL have port req_addr, input, ADDR_W bits: the target design address.
REQ-008 SHALL have port req_ena, input, 1 bit: enable the selected design after selection.
REQ-009 SHALL have port ctrl_sel_rst_n, output, 1 bit: active-low reset to the mux select counter.
REQ-010 SHALL have port ctrl_sel_inc, output, 1 bit: increment strobe to the mux select counter.
REQ-011 SHALL have port ctrl_ena, output, 1 bit: enable for the selected design.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a request completes.
REQ-013 SHALL have port cur_addr, output, ADDR_W bits: the address currently selected.
REQ-014 SHALL have port cur_valid, output, 1 bit: cur_addr is known.

Function
REQ-015 SHALL register all ctrl_* outputs; no combinational path from inputs to ctrl_*.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both high, capturing req_addr (A) and req_ena; that accept edge is cycle 0.
REQ-017 SHALL use FSM states IDLE, SEL_RST_LO, SEL_RST_HI, INC_HI, INC_LO, FINISH.
REQ-018 Same-address case: when cur_valid=1 and A==cur_addr, SHALL go IDLE->FINISH, set ctrl_ena=req_ena, and pulse done in cycle 1.
REQ-019 Full rebuild: when cur_valid=0 or A<cur_addr, SHALL set ctrl_ena=0 in cycle 1, hold ctrl_sel_rst_n=0 for cycles 1..P (P=PULSE_CYC), then 1 for cycles P+1..2P.
REQ-020 Incremental: when cur_valid=1 and A>cur_addr, SHALL skip the reset phase, set ctrl_ena=0, and issue D=A-cur_addr increments.
REQ-021 SHALL make each increment ctrl_sel_inc=1 for P cycles followed by ctrl_sel_inc=0 for P cycles; the increment count is A for a rebuild and D for an incremental request.
REQ-022 SHALL track cur_addr with the increments, so that it equals A at completion, and set cur_valid=1 in FINISH.
REQ-023 For A=0 on a rebuild, SHALL issue no increments and enter FINISH directly after the reset phase.
REQ-024 SHALL drive done=1 and ctrl_ena=req_ena in a single FINISH cycle, then return to IDLE the next cycle.
REQ-025 Latency: done SHALL occur at cycle 2P+2P*A+1 for a rebuild, at cycle 2P*D+1 for an incremental request, and at cycle 1 for the same-address case.
REQ-026 SHALL ignore req_valid while not in IDLE; req_ready=0 in that case.
REQ-027 SHALL hold ctrl_ena at 0 throughout every rebuild or incremental sequence.
REQ-028 SHALL accept a new request in IDLE on the cycle immediately after FINISH (back-to-back).
REQ-029 SHALL size the increment counter to ADDR_W bits with no wrap: A=2^ADDR_W-1 yields exactly that many pulses.

Reset
REQ-030 On rst=1 the block SHALL set: state IDLE, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, done=0, cur_valid=0, cur_addr=0, and req_ready=0.
REQ-031 rst asserted mid-sequence SHALL abort the sequence, emit no done pulse, and force cur_valid=0, so the next request performs a full rebuild.
REQ-032 req_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-033 Package tt_mux_ctrl_pkg SHALL hold the FSM state enum and the default ADDR_W constant.
REQ-034 The half-phase timer SHALL be a sub-module, tt_mux_pulse_timer, with a load input and a one-cycle expiry output, parameterised by PULSE_CYC.
REQ-035 The target implementation size SHALL be 150-300 lines of RTL total.

Verification (P=2, ADDR_W=10)
REQ-036 After reset, request A=3, ena=1 -> sel_rst_n low cycles 1-2; 3 inc pulses (each high 2, low 2); done and ctrl_ena=1 at cycle 17; cur_addr=3.
REQ-037 With A=3 selected, request A=5 -> no sel_rst_n pulse; 2 inc pulses; done at cycle 9; cur_addr=5.
REQ-038 With A=5 selected, request A=2 -> full rebuild; done at cycle 13; cur_addr=2. Then request A=2, ena=0 -> done at cycle 1 with ctrl_ena=0.
REQ-039 Request A=0 after reset -> reset phase only; done at cycle 5; zero inc pulses.
REQ-040 Assert rst at cycle 6 of an A=4 rebuild -> outputs at reset values next cycle; no done; cur_valid=0.
REQ-041 Hold req_valid high continuously across back-to-back requests -> each request is accepted only in IDLE; none lost or duplicated; ctrl_ena=0 during every sequence.
